// File: rtl/vram_write_ctrl.sv
// Text VRAM write-port sequencer: boot/software fills arbitrated round-robin
// against single CPU writes, all outputs registered in the MEMORY_CLK domain.
module vram_write_ctrl #(
    parameter int              ADDR_W    = 10,
    parameter int              DATA_W    = 8,
    parameter int              DEPTH     = 1024,
    parameter logic [DATA_W-1:0] FILL_MASK = 8'h7F,
    parameter bit              BOOT_FILL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] v_ada,
    output logic [DATA_W-1:0] v_din,
    output logic              v_cea
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

    state_t            state_r;
    logic [ADDR_W:0]   fill_idx_r;
    logic [DATA_W-1:0] seed_r;
    logic              mode_r;
    logic              last_grant_r;

    logic              cpu_elig_s;
    logic [DATA_W-1:0] fill_data_s;

    // Incrementing pattern wraps modulo 2^DATA_W before the mask is applied.
    function automatic logic [DATA_W-1:0] fill_pattern(
        input logic              mode,
        input logic [DATA_W-1:0] seed,
        input logic [DATA_W-1:0] idx_lo
    );
        logic [DATA_W-1:0] sum;
        sum = seed + idx_lo;
        if (mode) begin
            fill_pattern = sum & FILL_MASK;
        end else begin
            fill_pattern = seed;
        end
    endfunction

    // Eligibility excludes the ack cycle so one request is never granted twice.
    always_comb begin
        cpu_elig_s  = cpu_req && !cpu_ack;
        fill_data_s = fill_pattern(mode_r, seed_r, fill_idx_r[DATA_W-1:0]);
    end

    // Sequencer/arbiter: at most one registered write per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_ada        <= '0;
            v_din        <= '0;
            v_cea        <= 1'b0;
            cpu_ack      <= 1'b0;
            fill_done    <= 1'b0;
            fill_idx_r   <= '0;
            last_grant_r <= 1'b1;
            mode_r       <= 1'b1;
            seed_r       <= '0;
            state_r      <= BOOT_FILL ? ST_FILL : ST_IDLE;
            fill_busy    <= BOOT_FILL;
        end else begin
            v_cea     <= 1'b0;
            cpu_ack   <= 1'b0;
            fill_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu_elig_s) begin
                        v_ada        <= cpu_addr;
                        v_din        <= cpu_data;
                        v_cea        <= 1'b1;
                        cpu_ack      <= 1'b1;
                        last_grant_r <= 1'b1;
                    end
                    if (fill_start) begin
                        state_r    <= ST_FILL;
                        fill_idx_r <= '0;
                        mode_r     <= fill_mode;
                        seed_r     <= fill_value;
                        fill_busy  <= 1'b1;
                    end else begin
                        fill_busy  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    // busy stays set through the cycle that carries the last write
                    fill_busy <= 1'b1;
                    if (cpu_elig_s && !last_grant_r) begin
                        v_ada        <= cpu_addr;
                        v_din        <= cpu_data;
                        v_cea        <= 1'b1;
                        cpu_ack      <= 1'b1;
                        last_grant_r <= 1'b1;
                    end else begin
                        v_ada        <= fill_idx_r[ADDR_W-1:0];
                        v_din        <= fill_data_s;
                        v_cea        <= 1'b1;
                        fill_idx_r   <= fill_idx_r + IDX_ONE;
                        last_grant_r <= 1'b0;
                        if (fill_idx_r == LAST_IDX) begin
                            fill_done <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            state_r   <= ST_FILL;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    fill_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Bench for vram_write_ctrl: boot fill, table of idle CPU writes, randomized
// fill/CPU traffic against a transaction-level model, and reset abort.
module tb_vram_write_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fill_start;
    logic              fill_mode;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ack;
    logic [ADDR_W-1:0] v_ada;
    logic [DATA_W-1:0] v_din;
    logic              v_cea;

    int n_pass  = 0;
    int n_total = 0;
    int req_wait;
    logic [7:0] first3 [3];
    logic [7:0] boot_mem [DEPTH];

    always #5 clk = ~clk;

    vram_write_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .FILL_MASK(8'h7F), .BOOT_FILL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fill_start(fill_start), .fill_mode(fill_mode), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .v_ada(v_ada), .v_din(v_din), .v_cea(v_cea)
    );

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        bit         hold;
        logic [9:0] exp_ada;
        logic [7:0] exp_din;
    } cpu_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic new_req();
        cpu_req  = 1'b1;
        cpu_addr = 10'($urandom_range(0, DEPTH - 1));
        cpu_data = 8'($urandom_range(0, 255));
        req_wait = 0;
    endtask

    function automatic logic [7:0] exp_fill(input logic mode, input logic [7:0] value, input int idx);
        int t;
        t = (int'(value) + idx) % 256;
        return mode ? 8'(t % 128) : value;
    endfunction

    // One software fill with CPU traffic; checks every write against the model.
    task automatic run_fill(input logic mode, input logic [7:0] value, input bit continuous,
                            input int pulse_idx);
        int  fidx = 0, first_fill_cyc = 0, cpu_in_fill = 0, nwr = 0, gaps = 0;
        bit  prev_cpu = 1'b0, done = 1'b0, pulsed = 1'b0, fill_active = 1'b0;
        bit  granted, is_cpu;
        fill_start = 1'b1;
        fill_mode  = mode;
        fill_value = value;
        if (continuous) new_req();
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            tick();
            fill_start = 1'b0;
            granted = v_cea && cpu_ack;
            if (cpu_req && !granted) req_wait++;
            if (v_cea) begin
                nwr++;
                is_cpu = cpu_ack;
                if (continuous && nwr == 1) check("first_is_cpu", 32'(is_cpu), 32'd1);
                if (continuous && nwr == 2) check("second_is_fill0", {is_cpu, v_ada}, {1'b0, 10'd0});
                if (continuous && nwr > 1) check("alternate", 32'(is_cpu), 32'(!prev_cpu));
                if (is_cpu) begin
                    check("cpu_ada", 32'(v_ada), 32'(cpu_addr));
                    check("cpu_din", 32'(v_din), 32'(cpu_data));
                    check("cpu_wait", 32'(req_wait <= 1), 32'd1);
                    if (fill_active) begin
                        cpu_in_fill++;
                        check("no_adjacent_cpu", 32'(prev_cpu), 32'd0);
                    end
                    if (continuous || $urandom_range(0, 1) == 1) new_req();
                    else cpu_req = 1'b0;
                end else begin
                    check("fill_ada", 32'(v_ada), 32'(fidx));
                    check("fill_din", 32'(v_din), 32'(exp_fill(mode, value, fidx)));
                    if (fidx < 3) first3[fidx] = v_din;
                    if (!fill_active) first_fill_cyc = cyc;
                    fill_active = 1'b1;
                    fidx++;
                end
                prev_cpu = is_cpu;
            end else begin
                if (fill_active) gaps++;
                if (!cpu_req && $urandom_range(0, 1) == 1) new_req();
            end
            if (fill_active && !fill_busy) gaps++;
            if (fill_done) begin
                done = 1'b1;
                check("done_with_last", {v_cea, cpu_ack, v_ada}, {1'b1, 1'b0, 10'h3FF});
                check("busy_at_done", 32'(fill_busy), 32'd1);
                check("fill_count", 32'(fidx), 32'(DEPTH));
                check("fill_duration", 32'(cyc - first_fill_cyc + 1), 32'(DEPTH + cpu_in_fill));
                check("fill_no_gaps", 32'(gaps), 32'd0);
                if (continuous) check("contended_len", 32'(cyc + 1 >= 2047 && cyc + 1 <= 2049), 32'd1);
            end
            if (!pulsed && fidx == pulse_idx) begin
                fill_start = 1'b1;
                fill_mode  = ~mode;
                fill_value = 8'h55;
                pulsed     = 1'b1;
            end
        end
        check("fill_completed", 32'(done), 32'd1);
        cpu_req    = 1'b0;
        fill_start = 1'b0;
        tick();
        check("busy_after_fill", 32'(fill_busy), 32'd0);
    endtask

    initial begin
        cpu_vec_t vecs [4];
        int writes, gaps, bad, mem_bad;
        bit done_seen, found;

        vecs[0] = '{10'h123, 8'h41, 1'b1, 10'h123, 8'h41};
        vecs[1] = '{10'h3FF, 8'hFF, 1'b0, 10'h3FF, 8'hFF};
        vecs[2] = '{10'h000, 8'h00, 1'b1, 10'h000, 8'h00};
        vecs[3] = '{10'h2AA, 8'h55, 1'b0, 10'h2AA, 8'h55};

        rst_n = 1'b0; fill_start = 1'b0; fill_mode = 1'b0; fill_value = 8'h00;
        cpu_req = 1'b0; cpu_addr = 10'h000; cpu_data = 8'h00; req_wait = 0;
        tick();
        tick();
        check("rst_cea", 32'(v_cea), 32'd0);
        check("rst_ada", 32'(v_ada), 32'd0);
        check("rst_din", 32'(v_din), 32'd0);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_done", 32'(fill_done), 32'd0);
        check("rst_busy", 32'(fill_busy), 32'd1);

        // Boot fill with no CPU traffic
        rst_n = 1'b1;
        writes = 0; gaps = 0; bad = 0; done_seen = 1'b0;
        for (int c = 0; c < 1200 && !done_seen; c++) begin
            tick();
            if (v_cea) begin
                if (v_ada !== 10'(writes)) bad++;
                boot_mem[v_ada] = v_din;
                writes++;
            end else gaps++;
            if (fill_done) begin
                done_seen = 1'b1;
                check("boot_done_addr", 32'(v_ada), 32'h3FF);
                check("boot_done_busy", 32'(fill_busy), 32'd1);
            end
        end
        check("boot_done_seen", 32'(done_seen), 32'd1);
        check("boot_writes", 32'(writes), 32'(DEPTH));
        check("boot_gaps", 32'(gaps), 32'd0);
        check("boot_addr_order", 32'(bad), 32'd0);
        mem_bad = 0;
        for (int i = 0; i < DEPTH; i++) if (boot_mem[i] !== 8'(i % 128)) mem_bad++;
        check("boot_data", 32'(mem_bad), 32'd0);
        check("boot_7f", 32'(boot_mem[127]), 32'h7F);
        check("boot_80", 32'(boot_mem[128]), 32'h00);
        check("boot_3ff", 32'(boot_mem[1023]), 32'h7F);
        tick();
        check("boot_busy_low", 32'(fill_busy), 32'd0);
        check("boot_cea_low", 32'(v_cea), 32'd0);

        // Table of idle CPU writes
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1'b1; cpu_addr = vecs[i].addr; cpu_data = vecs[i].data;
            tick();
            check("idle_cea", 32'(v_cea), 32'd1);
            check("idle_ack", 32'(cpu_ack), 32'd1);
            check("idle_ada", 32'(v_ada), 32'(vecs[i].exp_ada));
            check("idle_din", 32'(v_din), 32'(vecs[i].exp_din));
            if (vecs[i].hold) begin
                tick();
                check("hold_no_cea", 32'(v_cea), 32'd0);
                check("hold_no_ack", 32'(cpu_ack), 32'd0);
            end
            cpu_req = 1'b0;
            tick();
            check("idle_quiet", 32'(v_cea), 32'd0);
        end

        // Contended constant fill, then incrementing fill with random traffic
        run_fill(1'b0, 8'h20, 1'b1, -1);
        run_fill(1'b1, 8'h7E, 1'b0, 300);
        check("seed_7e_0", 32'(first3[0]), 32'h7E);
        check("seed_7e_1", 32'(first3[1]), 32'h7F);
        check("seed_7e_2", 32'(first3[2]), 32'h00);

        // Reset abort at fill index 500 with a pending CPU request
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 700 && !found; c++) begin
            tick();
            if (v_cea && !cpu_ack && v_ada == 10'd499) found = 1'b1;
        end
        check("reach_idx_500", 32'(found), 32'd1);
        new_req();
        rst_n = 1'b0;
        tick();
        check("abort_cea", 32'(v_cea), 32'd0);
        check("abort_ada", 32'(v_ada), 32'd0);
        check("abort_din", 32'(v_din), 32'd0);
        check("abort_ack", 32'(cpu_ack), 32'd0);
        check("abort_done", 32'(fill_done), 32'd0);
        check("abort_busy", 32'(fill_busy), 32'd1);
        cpu_req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("restart_cea", 32'(v_cea), 32'd1);
        check("restart_ada", 32'(v_ada), 32'd0);
        check("restart_din", 32'(v_din), 32'd0);
        check("restart_no_ack", 32'(cpu_ack), 32'd0);
        new_req();
        tick();
        check("re_req_ack", 32'(cpu_ack), 32'd1);
        check("re_req_ada", 32'(v_ada), 32'(cpu_addr));
        cpu_req = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 1100 && !done_seen; c++) begin
            tick();
            if (fill_done) done_seen = 1'b1;
        end
        check("restart_fill_done", 32'(done_seen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
